// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared state encoding and mode constants for the oscillator channels
package osc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } osc_state_e;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/osc_chan.sv
// rtl/osc_chan.sv - one square-wave channel: IDLE/RUN/HOLD FSM, half-period down-counter, burst period counter
module osc_chan
  import osc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] half_period,
  input  logic             mode,
  input  logic [WIDTH-1:0] burst_len,
  output logic             osc_out,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  osc_state_e       state_q, state_d;
  logic             osc_q, osc_d;
  logic             done_q, done_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] hp_q, hp_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] len_eff;

  // A zero half-period behaves like one cycle, so the reload value is H-1 floored at 0
  function automatic logic [WIDTH-1:0] reload(input logic [WIDTH-1:0] h);
    return (h == '0) ? '0 : h - ONE;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      osc_q   <= 1'b1;
      done_q  <= 1'b0;
      mode_q  <= MODE_CONT;
      hp_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
    end else begin
      state_q <= state_d;
      osc_q   <= osc_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      hp_q    <= hp_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
    end
  end

  always_comb begin
    state_d = state_q;
    osc_d   = osc_q;
    done_d  = 1'b0;
    mode_d  = mode_q;
    hp_d    = hp_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    len_eff = (len_q == '0) ? ONE : len_q;
    case (state_q)
      ST_IDLE: begin
        osc_d = 1'b1;
        if (en) begin
          state_d = ST_RUN;
          hp_d    = half_period;
          mode_d  = mode;
          len_d   = burst_len;
          cnt_d   = reload(half_period);
          per_d   = '0;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
          osc_d   = 1'b1;
          cnt_d   = '0;
          per_d   = '0;
        end else if (cnt_q == '0) begin
          cnt_d = reload(hp_q);
          if (osc_q) begin
            osc_d = 1'b0;
          end else if (mode_q == MODE_BURST && (per_q + ONE) == len_eff) begin
            // Final rising edge of the burst: park high and flag completion
            state_d = ST_HOLD;
            osc_d   = 1'b1;
            done_d  = 1'b1;
            cnt_d   = '0;
            per_d   = '0;
          end else begin
            osc_d = 1'b1;
            if (mode_q == MODE_BURST) per_d = per_q + ONE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_HOLD: begin
        osc_d = 1'b1;
        if (!en) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        osc_d   = 1'b1;
      end
    endcase
  end

  always_comb begin
    osc_out = osc_q;
    busy    = (state_q == ST_RUN);
    done    = done_q;
  end

endmodule

// File: rtl/osc_gen.sv
// rtl/osc_gen.sv - CH independent square-wave generators with continuous and burst modes
module osc_gen
  import osc_pkg::*;
#(
  parameter int CH    = 2,
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       en,
  input  logic [CH*WIDTH-1:0] half_period,
  input  logic [CH-1:0]       mode,
  input  logic [CH*WIDTH-1:0] burst_len,
  output logic [CH-1:0]       osc_out,
  output logic [CH-1:0]       busy,
  output logic [CH-1:0]       done
);

  for (genvar g = 0; g < CH; g++) begin : g_chan
    osc_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en[g]),
      .half_period(half_period[g*WIDTH +: WIDTH]),
      .mode       (mode[g]),
      .burst_len  (burst_len[g*WIDTH +: WIDTH]),
      .osc_out    (osc_out[g]),
      .busy       (busy[g]),
      .done       (done[g])
    );
  end

endmodule

// File: tb/tb_osc_gen.sv
// tb/tb_osc_gen.sv - self-checking bench for osc_gen against a closed-form waveform model
module tb_osc_gen;

  localparam int CH = 2;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   en, mode;
  logic [CH*W-1:0] half_period, burst_len;
  logic [CH-1:0]   osc_out, busy, done;

  osc_gen #(.CH(CH), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .half_period(half_period), .mode(mode),
    .burst_len(burst_len), .osc_out(osc_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 run, 2 hold; t = edges since RUN entry
  int            m_st[CH], m_t[CH], m_h[CH], m_l[CH];
  bit            m_burst[CH];
  logic [CH-1:0] e_osc, e_busy, e_done;

  typedef struct {
    bit en; int hp; bit md; int bl;
    bit x_osc; bit x_busy; bit x_done;
  } vec_t;
  vec_t tbl[17];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < CH; i++) begin
      e_done[i] = 1'b0;
      if (!rst_n) begin
        m_st[i] = 0;
      end else begin
        case (m_st[i])
          0: if (en[i]) begin
            m_st[i]    = 1;
            m_t[i]     = 0;
            m_h[i]     = (half_period[i*W +: W] == 0) ? 1 : int'(half_period[i*W +: W]);
            m_l[i]     = (burst_len[i*W +: W] == 0) ? 1 : int'(burst_len[i*W +: W]);
            m_burst[i] = mode[i];
          end
          1: if (!en[i]) m_st[i] = 0;
             else begin
               m_t[i]++;
               if (m_burst[i] && m_t[i] == 2 * m_h[i] * m_l[i]) begin
                 m_st[i]   = 2;
                 e_done[i] = 1'b1;
               end
             end
          default: if (!en[i]) m_st[i] = 0;
        endcase
      end
      e_busy[i] = (m_st[i] == 1);
      e_osc[i]  = (m_st[i] == 1) ? (((m_t[i] / m_h[i]) % 2) == 0) : 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("osc_out", 8'(osc_out), 8'(e_osc));
    check("busy", 8'(busy), 8'(e_busy));
    check("done", 8'(done), 8'(e_done));
  endtask

  task automatic set_ch(input int i, input bit e, input int hp, input bit md, input int bl);
    en[i]              = e;
    half_period[i*W +: W] = W'(hp);
    mode[i]            = md;
    burst_len[i*W +: W]   = W'(bl);
  endtask

  initial begin
    int dcnt;
    rst_n = 1'b0; en = '0; mode = '0; half_period = '0; burst_len = '0;
    for (int i = 0; i < CH; i++) begin m_st[i] = 0; m_t[i] = 0; m_h[i] = 1; m_l[i] = 1; m_burst[i] = 0; end
    step(); step();
    check("reset_osc", 8'(osc_out), 8'(2'b11));
    check("reset_busy", 8'(busy), 8'(2'b00));
    rst_n = 1'b1;
    step();

    // Continuous H=3, mid-run half_period change, en drop mid-low, then H=0/len=0 burst
    tbl[0]  = '{1, 3, 0, 0, 1, 1, 0};
    tbl[1]  = '{1, 3, 0, 0, 1, 1, 0};
    tbl[2]  = '{1, 3, 0, 0, 1, 1, 0};
    tbl[3]  = '{1, 3, 0, 0, 0, 1, 0};
    tbl[4]  = '{1, 3, 0, 0, 0, 1, 0};
    tbl[5]  = '{1, 3, 0, 0, 0, 1, 0};
    tbl[6]  = '{1, 3, 0, 0, 1, 1, 0};
    tbl[7]  = '{1, 7, 0, 0, 1, 1, 0};
    tbl[8]  = '{1, 7, 0, 0, 1, 1, 0};
    tbl[9]  = '{1, 7, 0, 0, 0, 1, 0};
    tbl[10] = '{0, 7, 0, 0, 1, 0, 0};
    tbl[11] = '{1, 0, 1, 0, 1, 1, 0};
    tbl[12] = '{1, 0, 1, 0, 0, 1, 0};
    tbl[13] = '{1, 0, 1, 0, 1, 0, 1};
    tbl[14] = '{1, 0, 1, 0, 1, 0, 0};
    tbl[15] = '{0, 0, 1, 0, 1, 0, 0};
    tbl[16] = '{1, 1, 0, 0, 1, 1, 0};
    set_ch(1, 0, 0, 0, 0);
    for (int k = 0; k < 17; k++) begin
      set_ch(0, tbl[k].en, tbl[k].hp, tbl[k].md, tbl[k].bl);
      step();
      check($sformatf("tbl%0d_osc", k), 8'(osc_out[0]), 8'(tbl[k].x_osc));
      check($sformatf("tbl%0d_busy", k), 8'(busy[0]), 8'(tbl[k].x_busy));
      check($sformatf("tbl%0d_done", k), 8'(done[0]), 8'(tbl[k].x_done));
    end
    set_ch(0, 0, 0, 0, 0);
    step();

    // Burst H=2, len=3 with en held: one done, then HOLD until en cycles
    set_ch(0, 1, 2, 1, 3);
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin step(); if (done[0]) dcnt++; end
    check("burst_done_count", 8'(dcnt), 8'd1);
    check("burst_hold_busy", 8'(busy[0]), 8'd0);
    check("burst_hold_osc", 8'(osc_out[0]), 8'd1);
    set_ch(0, 0, 2, 1, 3); step();
    set_ch(0, 1, 2, 1, 3); step();
    check("burst_restart_busy", 8'(busy[0]), 8'd1);
    set_ch(0, 0, 0, 0, 0); step();

    // Two channels concurrently: ch0 continuous H=4, ch1 burst H=1 len=2
    set_ch(0, 1, 4, 0, 0);
    set_ch(1, 1, 1, 1, 2);
    for (int k = 0; k < 14; k++) step();
    set_ch(0, 0, 0, 0, 0); set_ch(1, 0, 0, 0, 0); step();

    // Reset mid-burst wins over en
    set_ch(0, 1, 3, 1, 4); set_ch(1, 1, 2, 1, 2);
    for (int k = 0; k < 5; k++) step();
    rst_n = 1'b0; step();
    check("midrst_osc", 8'(osc_out), 8'(2'b11));
    check("midrst_busy", 8'(busy), 8'd0);
    check("midrst_done", 8'(done), 8'd0);
    rst_n = 1'b1;
    set_ch(0, 0, 0, 0, 0); set_ch(1, 0, 0, 0, 0); step();

    // Period 6 persists through a half_period change, becomes 14 after re-entry
    set_ch(0, 1, 3, 0, 0);
    for (int k = 0; k < 8; k++) step();
    set_ch(0, 1, 7, 0, 0);
    for (int k = 0; k < 12; k++) step();
    set_ch(0, 0, 7, 0, 0); step();
    set_ch(0, 1, 7, 0, 0);
    for (int k = 0; k < 30; k++) step();
    set_ch(0, 0, 0, 0, 0); step();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 11) == 0) en[i] = ~en[i];
        if (!en[i] || $urandom_range(0, 4) == 0) begin
          half_period[i*W +: W] = W'($urandom_range(0, 5));
          burst_len[i*W +: W]   = W'($urandom_range(0, 3));
          mode[i]               = 1'($urandom_range(0, 1));
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/osc_gen.md
OSC_GEN -- requirements
Module: osc_gen

Interface
REQ-001 Parameter CH, default 2: number of independent oscillator channels (1..8).
REQ-002 Parameter WIDTH, default 8: bit width of the half-period and burst-length fields.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  CH  per-channel enable, sampled on the rising edge of clk.
REQ-006 half_period  input  CH*WIDTH  per-channel half-period in clk cycles; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 mode  input  CH  per-channel mode: 0 = continuous, 1 = burst.
REQ-008 burst_len  input  CH*WIDTH  per-channel number of full output periods in burst mode; same packing as half_period.
REQ-009 osc_out  output  CH  per-channel square wave; idle level is 1.
REQ-010 busy  output  CH  1 while the channel is in RUN.
REQ-011 done  output  CH  one-cycle pulse when a burst completes.

Function
REQ-012 Each channel SHALL implement an FSM with states IDLE, RUN and HOLD, independent of all other channels.
REQ-013 IDLE: osc_out=1, busy=0; if en=1 at an edge, the channel SHALL enter RUN at that edge.
REQ-014 On entry to RUN, the channel SHALL latch half_period, mode and burst_len; input changes during RUN SHALL be ignored.
REQ-015 On entry to RUN, the down-counter SHALL load H-1, where H = latched half_period; H=0 SHALL be treated as H=1.
REQ-016 In RUN, at an edge with counter==0, the channel SHALL toggle osc_out and reload H-1; otherwise it SHALL decrement.
REQ-017 Output pattern: H cycles high, then H cycles low, period 2H; the first low phase starts H cycles after RUN entry.
REQ-018 Continuous mode: the channel SHALL stay in RUN while en=1.
REQ-019 Burst mode: a period counter SHALL increment on each 0->1 toggle of osc_out; burst_len=0 SHALL be treated as 1.
REQ-020 Burst mode: on the 0->1 toggle that reaches the latched burst_len, osc_out SHALL return to 1, done SHALL pulse for exactly that cycle, and the channel SHALL enter HOLD.
REQ-021 HOLD: osc_out=1, busy=0; the channel SHALL return to IDLE only when en=0, so each new burst requires a new rising edge of en.
REQ-022 en=0 in RUN SHALL force IDLE at that edge: osc_out=1, counters cleared, no done pulse.
REQ-023 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-024 When rst_n=0 at a rising clk edge, every channel SHALL enter IDLE with osc_out=1, busy=0, done=0 and all counters cleared.
REQ-025 Reset SHALL take priority over en in the same cycle, including mid-RUN and mid-burst.

Structure
REQ-026 A shared package osc_pkg SHALL hold the state encoding (IDLE/RUN/HOLD) and the mode constants MODE_CONT=0 and MODE_BURST=1.
REQ-027 The per-channel logic SHALL be a sub-module osc_chan, instantiated CH times by a generate loop in osc_gen.

Verification
REQ-028 Continuous, ch0, H=3, en held high: osc_out[0] = 1,1,1,0,0,0,1,... from the RUN-entry edge; busy[0]=1; done never pulses.
REQ-029 Burst, H=2, burst_len=3, en held high: exactly 3 full periods, done pulses once on the final 0->1 edge, then HOLD with osc_out=1; no restart until en goes 0 then 1.
REQ-030 H=0 and burst_len=0: the channel toggles every cycle, and in burst mode one period is followed by done.
REQ-031 Channel 0 in continuous mode with H=4 and channel 1 in burst mode with H=1, burst_len=2, both running at once: the waveforms are independent and correct per channel.
REQ-032 en dropped mid-low-phase: at the next edge osc_out=1, busy=0, done=0; rst_n=0 mid-burst gives all outputs at reset values on the next edge.
REQ-033 half_period changed from 3 to 7 during RUN: the period stays 6 until en is dropped and re-asserted, after which the period is 14.
